// File: rtl/coherent_sum_accumulator.sv
// coherent_sum_accumulator: read-modify-write accumulation of correlator dumps into coherent-result RAM
module coherent_sum_accumulator #(
    parameter int ACC_WIDTH  = 20,
    parameter int BASE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic [BASE_WIDTH-1:0]     channel_base,
    input  logic                      coherent_sum_valid,
    input  logic [4:0]                cor_index,
    input  logic [15:0]               i_coherent_sum,
    input  logic [15:0]               q_coherent_sum,
    input  logic                      coherent_done,
    output logic                      ram_rd_en,
    output logic [BASE_WIDTH+2:0]     ram_rd_addr,
    input  logic [2*ACC_WIDTH-1:0]    ram_rd_data,
    output logic                      ram_wr_en,
    output logic [BASE_WIDTH+2:0]     ram_wr_addr,
    output logic [2*ACC_WIDTH-1:0]    ram_wr_data,
    input  logic                      result_ack,
    output logic                      result_ready,
    output logic                      overwrite_err,
    output logic                      busy
);
    localparam int AW = BASE_WIDTH + 3;
    localparam int A  = ACC_WIDTH;

    function automatic logic [A-1:0] sat_add(input logic [A-1:0] acc, input logic [15:0] x);
        logic [A:0] s;
        s = {acc[A-1], acc} + {{(A-15){x[15]}}, x};
        return (s[A] != s[A-1]) ? {s[A], {(A-1){~s[A]}}} : s[A-1:0];
    endfunction

    logic          r_r_vld, r_r_new, r_r_prot;
    logic [AW-1:0] r_r_addr;
    logic [15:0]   r_r_i, r_r_q;
    logic          r_e_vld, r_e_new, r_e_prot, r_e_done;
    logic [AW-1:0] r_e_addr;
    logic [15:0]   r_e_i, r_e_q;
    logic          r_w_vld, r_w_prot;
    logic [AW-1:0] r_w_addr;
    logic [2*A-1:0] r_w_data;
    logic          r_lw_vld;
    logic [AW-1:0] r_lw_addr;
    logic [2*A-1:0] r_lw_data;
    logic          r_rdy, r_err;
    logic          w_w_hit, w_lw_hit, w_rdy_set;
    logic [2*A-1:0] w_opnd, w_sum;

    // operand select: new period clears, then youngest in-flight write wins over the RAM
    always_comb begin
        w_w_hit   = r_w_vld & ~r_w_prot & (r_w_addr == r_e_addr);
        w_lw_hit  = r_lw_vld & (r_lw_addr == r_e_addr);
        w_opnd    = r_e_new ? '0 : w_w_hit ? r_w_data : w_lw_hit ? r_lw_data : ram_rd_data;
        w_sum     = {sat_add(w_opnd[2*A-1:A], r_e_i), sat_add(w_opnd[A-1:0], r_e_q)};
        w_rdy_set = r_e_vld & r_e_done & (r_e_addr[2:0] == 3'd7);
    end

    // three-stage pipeline R -> E -> W plus the one-cycle last-written bypass register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_r_vld   <= 1'b0;
            r_r_new   <= 1'b0;
            r_r_prot  <= 1'b0;
            r_r_addr  <= '0;
            r_r_i     <= '0;
            r_r_q     <= '0;
            r_e_vld   <= 1'b0;
            r_e_new   <= 1'b0;
            r_e_prot  <= 1'b0;
            r_e_done  <= 1'b0;
            r_e_addr  <= '0;
            r_e_i     <= '0;
            r_e_q     <= '0;
            r_w_vld   <= 1'b0;
            r_w_prot  <= 1'b0;
            r_w_addr  <= '0;
            r_w_data  <= '0;
            r_lw_vld  <= 1'b0;
            r_lw_addr <= '0;
            r_lw_data <= '0;
        end else begin
            r_r_vld   <= coherent_sum_valid;
            r_r_new   <= cor_index[0];
            r_r_prot  <= cor_index[1];
            r_r_addr  <= {channel_base, cor_index[4:2]};
            r_r_i     <= i_coherent_sum;
            r_r_q     <= q_coherent_sum;
            r_e_vld   <= r_r_vld;
            r_e_new   <= r_r_new;
            r_e_prot  <= r_r_prot;
            r_e_done  <= coherent_done;
            r_e_addr  <= r_r_addr;
            r_e_i     <= r_r_i;
            r_e_q     <= r_r_q;
            r_w_vld   <= r_e_vld;
            r_w_prot  <= r_e_prot;
            r_w_addr  <= r_e_addr;
            r_w_data  <= w_sum;
            r_lw_vld  <= ram_wr_en;
            r_lw_addr <= ram_wr_en ? r_w_addr : r_lw_addr;
            r_lw_data <= ram_wr_en ? r_w_data : r_lw_data;
        end
    end

    // sticky firmware flags; a new set beats a coincident ack
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_rdy <= w_rdy_set | (r_rdy & ~result_ack);
            r_err <= (r_e_vld & r_e_prot) | (r_err & ~result_ack);
        end
    end

    assign ram_rd_en     = r_r_vld & ~r_r_new & ~r_r_prot;
    assign ram_rd_addr   = r_r_addr;
    assign ram_wr_en     = r_w_vld & ~r_w_prot;
    assign ram_wr_addr   = r_w_addr;
    assign ram_wr_data   = r_w_data;
    assign result_ready  = r_rdy;
    assign overwrite_err = r_err;
    assign busy          = r_r_vld | r_e_vld | r_w_vld;
endmodule

// File: tb/tb_coherent_sum_accumulator.sv
// tb_coherent_sum_accumulator: scoreboard bench with a RAM model and a reference accumulator
module tb_coherent_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst_b;
    logic [5:0]  channel_base;
    logic        coherent_sum_valid;
    logic [4:0]  cor_index;
    logic [15:0] i_coherent_sum, q_coherent_sum;
    logic        coherent_done;
    logic        ram_rd_en, ram_wr_en;
    logic [8:0]  ram_rd_addr, ram_wr_addr;
    logic [39:0] ram_rd_data, ram_wr_data;
    logic        result_ack, result_ready, overwrite_err, busy;

    logic [39:0] mem [0:511] = '{default: '0};
    logic [39:0] ref_mem [0:511];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr;
    logic [39:0] pl_data;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {logic [8:0] addr; logic [39:0] data; int cyc;} wexp_t;
    typedef struct {logic [8:0] addr; int cyc;} rexp_t;
    wexp_t wq[$];
    rexp_t rdq[$];

    coherent_sum_accumulator #(.ACC_WIDTH(20), .BASE_WIDTH(6)) dut (
        .clk(clk), .rst_b(rst_b), .channel_base(channel_base),
        .coherent_sum_valid(coherent_sum_valid), .cor_index(cor_index),
        .i_coherent_sum(i_coherent_sum), .q_coherent_sum(q_coherent_sum),
        .coherent_done(coherent_done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .result_ack(result_ack), .result_ready(result_ready),
        .overwrite_err(overwrite_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    always @(negedge clk) begin
        if (rst_b) begin
            if (ram_wr_en) begin
                tests++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, ram_wr_addr, ram_wr_data);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    if (ram_wr_addr !== e.addr || ram_wr_data !== e.data || cyc !== e.cyc) begin
                        fails++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                                 ram_wr_addr, ram_wr_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (ram_rd_en) begin
                tests++;
                if (rdq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read cyc=%0d addr=%0d", cyc, ram_rd_addr);
                end else begin
                    rexp_t r;
                    r = rdq.pop_front();
                    if (ram_rd_addr !== r.addr || cyc !== r.cyc) begin
                        fails++;
                        $display("FAIL read got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", ram_rd_addr, cyc, r.addr, r.cyc);
                    end
                end
            end
        end
    end

    function automatic logic [19:0] msat(input logic [19:0] acc, input int x);
        int s;
        s = int'($signed(acc)) + x;
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
        return s[19:0];
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic drive(input logic [5:0] base, input logic [2:0] cor, input logic prot, input logic nw,
                         input int i, input int q, input logic done);
        logic [8:0]  a;
        logic [19:0] ni, nq;
        a = {base, cor};
        channel_base = base;
        cor_index = {cor, prot, nw};
        i_coherent_sum = 16'(i);
        q_coherent_sum = 16'(q);
        coherent_done = done;
        coherent_sum_valid = 1'b1;
        if (!prot) begin
            if (!nw) rdq.push_back('{a, cyc + 1});
            ni = msat(nw ? 20'd0 : ref_mem[a][39:20], i);
            nq = msat(nw ? 20'd0 : ref_mem[a][19:0], q);
            ref_mem[a] = {ni, nq};
            wq.push_back('{a, {ni, nq}, cyc + 3});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        coherent_sum_valid = 1'b0;
        cor_index = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [8:0] a, input logic [39:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ram_rd_en, ram_wr_en, ram_rd_addr, ram_wr_addr, ram_wr_data, result_ready, overwrite_err, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got rd=%b wr=%b wd=%h rdy=%b err=%b busy=%b exp all 0",
                     ram_rd_en, ram_wr_en, ram_wr_data, result_ready, overwrite_err, busy);
        end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(6'd5, 3'd3, 1'b0, 1'b1, 100, -50, 1'b0);
        idle(0);
        for (int k = 1; k <= 4; k++) begin
            tests++;
            if (busy !== (k <= 3)) begin
                fails++;
                $display("FAIL single_busy T+%0d got %b exp %b", k, busy, k <= 3);
            end
            @(negedge clk);
        end
        tests++;
        if (mem[43] !== {20'd100, 20'hFFFCE}) begin
            fails++;
            $display("FAIL single_mem got %h exp %h", mem[43], {20'd100, 20'hFFFCE});
        end
    endtask

    task automatic test_rmw();
        preload(9'd43, {20'd1000, 20'd2000});
        drive(6'd5, 3'd3, 1'b0, 1'b0, -10, 20, 1'b0);
        idle(4);
        tests++;
        if (mem[43] !== {20'd990, 20'd2020}) begin
            fails++;
            $display("FAIL rmw_mem got %h exp %h", mem[43], {20'd990, 20'd2020});
        end
    endtask

    task automatic test_saturate();
        preload(9'd43, {20'h7FFFB, 20'h80003});
        drive(6'd5, 3'd3, 1'b0, 1'b0, 100, -100, 1'b0);
        idle(4);
        tests++;
        if (mem[43] !== {20'h7FFFF, 20'h80000}) begin
            fails++;
            $display("FAIL saturate_mem got %h exp %h", mem[43], {20'h7FFFF, 20'h80000});
        end
    endtask

    task automatic test_protect();
        drive(6'd5, 3'd2, 1'b1, 1'b0, 7, 7, 1'b0);
        idle(0);
        for (int k = 1; k <= 3; k++) begin
            tests++;
            if (overwrite_err !== (k == 3)) begin
                fails++;
                $display("FAIL protect_err T+%0d got %b exp %b", k, overwrite_err, k == 3);
            end
            if (k < 3) @(negedge clk);
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        tests++;
        if (overwrite_err !== 1'b0) begin
            fails++;
            $display("FAIL protect_ack got %b exp 0", overwrite_err);
        end
        idle(2);
    endtask

    task automatic test_result_ready();
        drive(6'd5, 3'd7, 1'b0, 1'b1, 1, 2, 1'b0);
        idle(3);
        tests++;
        if (result_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_without_done got %b exp 0", result_ready);
        end
        drive(6'd5, 3'd6, 1'b0, 1'b1, 1, 2, 1'b1);
        idle(3);
        coherent_done = 1'b0;
        tests++;
        if (result_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_wrong_cor got %b exp 0", result_ready);
        end
        drive(6'd5, 3'd7, 1'b0, 1'b1, 3, 4, 1'b1);
        idle(1);
        coherent_done = 1'b0;
        result_ack = 1'b1;
        tests++;
        if (result_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_early got %b exp 0", result_ready);
        end
        @(negedge clk);
        tests++;
        if (result_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_set_over_ack got %b exp 1", result_ready);
        end
        @(negedge clk);
        result_ack = 1'b0;
        tests++;
        if (result_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_ack_clear got %b exp 0", result_ready);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) drive(6'd2, 3'(k), 1'b0, 1'b1, rnd16(), rnd16(), 1'b0);
        idle(2);
        for (int k = 0; k < 8; k++) drive(6'd2, 3'(k), 1'b0, 1'b0, rnd16(), rnd16(), 1'b0);
        for (int n = 0; n < 60; n++) begin
            drive(6'd2, 3'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  rnd16(), rnd16(), 1'b0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(5);
        for (int k = 16; k < 24; k++) begin
            tests++;
            if (mem[k] !== ref_mem[k]) begin
                fails++;
                $display("FAIL b2b_mem addr=%0d got %h exp %h", k, mem[k], ref_mem[k]);
            end
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        drive(6'd3, 3'd1, 1'b1, 1'b0, 5, 5, 1'b0);
        drive(6'd3, 3'd2, 1'b0, 1'b1, 11, 12, 1'b0);
        drive(6'd3, 3'd4, 1'b0, 1'b0, 13, 14, 1'b0);
        tests++;
        if (overwrite_err !== 1'b1) begin
            fails++;
            $display("FAIL midrst_err_before got %b exp 1", overwrite_err);
        end
        rst_b = 1'b0;
        coherent_sum_valid = 1'b0;
        wq.delete();
        rdq.delete();
        #1;
        tests++;
        if ({ram_rd_en, ram_wr_en, ram_rd_addr, ram_wr_addr, ram_wr_data, result_ready, overwrite_err, busy} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs got rd=%b wr=%b wd=%h rdy=%b err=%b busy=%b exp all 0",
                     ram_rd_en, ram_wr_en, ram_wr_data, result_ready, overwrite_err, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (ram_wr_en !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midrst_hold got wr=%b busy=%b exp 0 0", ram_wr_en, busy);
            end
        end
        rst_b = 1'b1;
        idle(4);
        for (int a = 0; a < 512; a++) ref_mem[a] = mem[a];
    endtask

    initial begin
        for (int a = 0; a < 512; a++) ref_mem[a] = '0;
        channel_base = '0;
        coherent_sum_valid = 1'b0;
        cor_index = '0;
        i_coherent_sum = '0;
        q_coherent_sum = '0;
        coherent_done = 1'b0;
        result_ack = 1'b0;
        test_reset();
        test_single();
        test_rmw();
        test_saturate();
        test_protect();
        test_result_ready();
        test_back_to_back();
        test_mid_reset();
        tests++;
        if (wq.size() != 0 || rdq.size() != 0) begin
            fails++;
            $display("FAIL pending_expect got wq=%0d rdq=%0d exp 0 0", wq.size(), rdq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coherent_sum_accumulator.md
Name: coherent_sum_accumulator

Overview:
- Receiving end of the correlator dump interface.
- Takes each dumped I/Q coherent partial sum with its correlator index and accumulates it into the channel's coherent-result RAM region by read-modify-write.
- Handles new-period overwrite, overwrite-protect suppression and read-after-write hazards on back-to-back dumps.
- Raises a sticky result-ready flag for firmware when a coherent period completes.

Parameters:
- ACC_WIDTH, 20, width of each stored I or Q accumulator (signed); must be ≥ 16.
- BASE_WIDTH, 6, width of channel base address; RAM address width is BASE_WIDTH+3.

Ports:
- clk  input  1  system clock
- rst_b  input  1  asynchronous active-low reset
- channel_base  input  BASE_WIDTH  RAM region of the active channel; stable while any dump is in flight
- coherent_sum_valid  input  1  one-cycle strobe, dump data valid
- cor_index  input  5  bits4:2 correlator 0–7; bit1 overwrite-protect; bit0 first dump of a new coherent period
- i_coherent_sum  input  16  signed I partial sum
- q_coherent_sum  input  16  signed Q partial sum
- coherent_done  input  1  level from dump logic: coherent period complete
- ram_rd_en  output  1  RAM read strobe
- ram_rd_addr  output  BASE_WIDTH+3  read address
- ram_rd_data  input  2*ACC_WIDTH  {I,Q}, valid exactly 1 cycle after ram_rd_en
- ram_wr_en  output  1  RAM write strobe
- ram_wr_addr  output  BASE_WIDTH+3  write address
- ram_wr_data  output  2*ACC_WIDTH  {I,Q} accumulated value
- result_ack  input  1  firmware clears result_ready and overwrite_err
- result_ready  output  1  sticky: coherent result of all correlators written
- overwrite_err  output  1  sticky: a protected dump was dropped
- busy  output  1  any pipeline stage occupied

Behaviour:
- Reset: all outputs and pipeline registers go to 0.
- RAM write-during-read to the same address returns the old data.
- Address is {channel_base, cor_index[4:2]}, captured at input.

Pipeline (fully pipelined, one dump accepted per cycle, no backpressure):
- Stage R, cycle T+1 after the valid at T:
  - ram_rd_en=1, ram_rd_addr=addr.
  - The RAM read is skipped (ram_rd_en=0) when bit0=1 or bit1=1.
  - Data, addr and flags are registered.
- Stage E, cycle T+2, operand selection in priority order:
  - if bit0=1: operand = 0.
  - else if stage W of this cycle holds the same addr: operand = W data.
  - else if the last-written register (write committed at T+2-1) holds the same addr: operand = that value.
  - else: operand = ram_rd_data.
- Stage E sum: sign-extend the 16-bit inputs to ACC_WIDTH and add to the operand with signed saturation to ±(2^(ACC_WIDTH-1)-1/−2^(ACC_WIDTH-1)); I and Q saturate independently. The result is registered.
- Stage W, cycle T+3: ram_wr_en=1 with addr and sum, except protected entries.
- Fixed latency: input valid to write = 3 cycles.

Overwrite protect:
- A dump with bit1=1 is carried through the pipeline but generates no read and no write.
- It sets overwrite_err at T+3.
- It does not update the last-written register.

Result ready:
- Set at cycle T+3 of a dump with cor_index[4:2]==7 when coherent_done was high at T+1.
- result_ack clears result_ready and overwrite_err the next cycle.
- Set has priority over a simultaneous ack.

Busy: OR of the stage-valid bits.

Mid-operation reset: all in-flight dumps are discarded, with no partial write.

channel_base change while busy=1: undefined; firmware must not do it.

Test Plan:
- Single dump, cor=3, bit0=1, I=100, Q=−50, base=5 → no read; write at T+3, addr=43, data {100,−50}; busy high for T+1..T+3.
- Preload addr 43 with {1000,2000}; dump cor=3, bit0=0, I=−10, Q=20 → read at T+1, write {990,2020} at T+3.
- 8 back-to-back dumps cor 0..7, then the same 8 again (bit0=0) two cycles later → forwarding paths exercised; each RAM word ends at the sum of both; no lost updates vs. reference model.
- Preload {2^19−5, −2^19+3}; dump I=100, Q=−100 → saturates to {2^19−1, −2^19}.
- Dump with bit1=1 → no ram_rd_en/ram_wr_en, overwrite_err=1 at T+3; result_ack clears it next cycle.
- coherent_done=1 with cor=7 dump → result_ready at T+3; result_ack in the same cycle leaves it set; next-cycle ack clears; assert rst_b mid-burst → no further writes, all outputs 0.
